// File: rtl/line_event_pkg.sv
// ---------------------------------------------------------------------------
// line_event_pkg
// Shared sizing for the one-hot event line encoder and the decoder-side
// benches that drive it.
//   NUM_LINES : number of one-hot event lines (decoder outputs po0..po15)
//   IDX_W     : width of an encoded line index
//   DROP_W    : width of the saturating drop counter
// ---------------------------------------------------------------------------
package line_event_pkg;

    localparam int NUM_LINES = 16;
    localparam int IDX_W     = 4;
    localparam int DROP_W    = 8;

    // Round-robin successor of an index; wraps naturally at NUM_LINES
    // because IDX_W bits cover exactly NUM_LINES values.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return i + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// ---------------------------------------------------------------------------
// rr_pick16
// Purely combinational round-robin search over 16 request bits.
// The search begins at 'start' and walks upward, wrapping from 15 to 0;
// the first set bit met is reported.
// Ports:
//   req   [15:0] in  : request bits to search
//   start [3:0]  in  : first position examined
//   found        out : at least one request bit is set
//   idx   [3:0]  out : index of the chosen request (start when none found)
// ---------------------------------------------------------------------------
module rr_pick16
    import line_event_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  start,
    output logic        found,
    output logic [3:0]  idx
);

    logic [3:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = start;
        pos   = start;
        // Walk offsets 0..15 from start; 4-bit addition supplies the wrap.
        for (int k = 0; k < 16; k++) begin
            pos = start + 4'(k);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/line_event_encoder.sv
// ---------------------------------------------------------------------------
// line_event_encoder
// Collects strobes from the 16 one-hot decoder outputs into a sticky pending
// register and hands them out one index at a time through a valid/ready
// output register, choosing among pending lines round-robin. Events that
// arrive on a line which already has an unserved event are counted as drops.
// Ports:
//   clk        in        : clock, all state on the rising edge
//   rst_n      in        : asynchronous active-low reset
//   line_in    in  [15:0]: level-sampled event strobes, one per line
//   idx_out    out [3:0] : index of the granted line
//   idx_valid  out       : idx_out holds an event
//   idx_ready  in        : consumer takes idx_out this cycle
//   pending    out [15:0]: sticky per-line event register (visibility)
//   drop_cnt   out [7:0] : saturating count of cycles with any drop
// ---------------------------------------------------------------------------
module line_event_encoder
    import line_event_pkg::*;
#(
    // rr_pick16 is a fixed 16-wide search, so NUM_LINES stays at 16.
    parameter int NUM_LINES = line_event_pkg::NUM_LINES,
    parameter int DROP_W    = line_event_pkg::DROP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] line_in,
    output logic [IDX_W-1:0]     idx_out,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic [NUM_LINES-1:0] pending,
    output logic [DROP_W-1:0]    drop_cnt
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [IDX_W-1:0]     last_idx;
    logic [IDX_W-1:0]     search_start;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 out_free;
    logic                 grant;
    logic [NUM_LINES-1:0] grant_mask;
    logic [NUM_LINES-1:0] pending_next;
    logic                 drop_any;

    // ---- stage: search over registered pending (never raw line_in) ----
    assign search_start = next_idx(last_idx);

    rr_pick16 u_pick (
        .req   (pending),
        .start (search_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The output register may be reloaded when empty or being consumed.
    assign out_free = !idx_valid || idx_ready;
    assign grant    = out_free && pick_found;

    always_comb begin
        grant_mask = '0;
        if (grant) begin
            grant_mask[pick_idx] = 1'b1;
        end
    end

    // A new strobe on a granted line re-arms it as a fresh event; only a
    // strobe on a line whose earlier event is still waiting is lost.
    assign pending_next = (pending & ~grant_mask) | line_in;
    assign drop_any     = |(line_in & pending & ~grant_mask);

    // ---- stage: state registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
            drop_cnt  <= '0;
            // All ones so the first search after reset starts at line 0.
            last_idx  <= '1;
        end else begin
            pending <= pending_next;
            if (grant) begin
                idx_out   <= pick_idx;
                idx_valid <= 1'b1;
                last_idx  <= pick_idx;
            end else if (out_free) begin
                // Nothing to hand out: drop valid, keep last index visible.
                idx_valid <= 1'b0;
            end
            if (drop_any) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_line_event_encoder.sv
module tb_line_event_encoder;
    import line_event_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] line_in;
    logic [3:0]  idx_out;
    logic        idx_valid;
    logic        idx_ready;
    logic [15:0] pending;
    logic [7:0]  drop_cnt;

    int nchk;
    int nfail;

    line_event_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (line_in),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;   // apply a reset before this vector
        logic [15:0] line;
        logic        rdy;
        logic        v;
        logic [3:0]  idx;
        logic [15:0] pend;
        logic [7:0]  drop;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [3:0] i,
                             input logic [15:0] p, input logic [7:0] d);
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(v));
        chk({tag, ".idx_out"},   32'(idx_out),   32'(i));
        chk({tag, ".pending"},   32'(pending),   32'(p));
        chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(d));
    endtask

    // One edge with the given inputs; outputs settle #1 after the edge.
    task automatic step(input logic [15:0] l, input logic r);
        @(negedge clk);
        line_in   = l;
        idx_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle; outputs must clear without an edge.
    // line_in is held high during reset and must be lost.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        line_in   = 16'hFFFF;
        idx_ready = 1'b0;
        #1;
        chk_state("rst_async", 1'b0, 4'd0, 16'h0000, 8'd0);
        @(posedge clk);
        #1;
        chk("rst_edge.pending", 32'(pending), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        line_in = 16'h0000;
    endtask

    initial begin
        nchk      = 0;
        nfail     = 0;
        rst_n     = 1'b0;
        line_in   = 16'h0000;
        idx_ready = 1'b0;

        //             rst   line      rdy  v     idx    pend      drop
        // single pulse on line 0
        tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 4'd0,  16'h0001, 8'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h0000, 8'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 8'd0};
        // three lines at once, one per cycle: 0, 8, 15
        tbl[3]  = '{1'b1, 16'h8101, 1'b1, 1'b0, 4'd0,  16'h8101, 8'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h8100, 8'd0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd8,  16'h8000, 8'd0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd15, 16'h0000, 8'd0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd15, 16'h0000, 8'd0};
        // line 3 pulsed three times while stalled: out reg, pending, drop
        tbl[8]  = '{1'b1, 16'h0008, 1'b0, 1'b0, 4'd0,  16'h0008, 8'd0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3,  16'h0000, 8'd0};
        tbl[10] = '{1'b0, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 8'd0};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3,  16'h0008, 8'd0};
        tbl[12] = '{1'b0, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 8'd1};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd3,  16'h0000, 8'd1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3,  16'h0000, 8'd1};
        // line 7 held across its grant edge: re-armed, no drop
        tbl[15] = '{1'b1, 16'h0080, 1'b1, 1'b0, 4'd0,  16'h0080, 8'd0};
        tbl[16] = '{1'b0, 16'h0080, 1'b1, 1'b1, 4'd7,  16'h0080, 8'd0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd7,  16'h0000, 8'd0};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd7,  16'h0000, 8'd0};

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].line, tbl[i].rdy);
            chk_state($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].pend, tbl[i].drop);
        end

        // Stalled consumer: index 5 held 10 cycles, second pulse absorbed.
        do_reset();
        step(16'h0020, 1'b0);
        step(16'h0000, 1'b0);
        chk_state("hold_load", 1'b1, 4'd5, 16'h0000, 8'd0);
        for (int c = 0; c < 10; c++) begin
            step((c == 3) ? 16'h0020 : 16'h0000, 1'b0);
            chk($sformatf("hold%0d.valid", c), 32'(idx_valid), 32'd1);
            chk($sformatf("hold%0d.idx", c),   32'(idx_out),   32'd5);
        end
        chk_state("hold_end", 1'b1, 4'd5, 16'h0020, 8'd0);
        step(16'h0000, 1'b1);
        chk_state("hold_second", 1'b1, 4'd5, 16'h0000, 8'd0);
        step(16'h0000, 1'b1);
        chk_state("hold_drain", 1'b0, 4'd5, 16'h0000, 8'd0);

        // Drop counter saturation: line 3 held high while stalled.
        do_reset();
        step(16'h0008, 1'b0);
        step(16'h0008, 1'b0);
        chk_state("sat_grant", 1'b1, 4'd3, 16'h0008, 8'd0);
        for (int c = 2; c < 256; c++) step(16'h0008, 1'b0);
        chk("sat_254", 32'(drop_cnt), 32'd254);
        step(16'h0008, 1'b0);
        chk("sat_255", 32'(drop_cnt), 32'd255);
        for (int c = 0; c < 5; c++) step(16'h0008, 1'b0);
        chk("sat_hold", 32'(drop_cnt), 32'd255);

        // Reset mid-transfer with pending 0x00F0, then search restarts at 0.
        do_reset();
        step(16'h0020, 1'b0);
        step(16'h0000, 1'b0);
        step(16'h00F0, 1'b0);
        chk_state("pre_rst", 1'b1, 4'd5, 16'h00F0, 8'd0);
        do_reset();
        step(16'h0204, 1'b1);
        chk_state("post_rst0", 1'b0, 4'd0, 16'h0204, 8'd0);
        step(16'h0000, 1'b1);
        chk_state("post_rst1", 1'b1, 4'd2, 16'h0200, 8'd0);
        step(16'h0000, 1'b1);
        chk_state("post_rst2", 1'b1, 4'd9, 16'h0000, 8'd0);
        step(16'h0000, 1'b1);
        chk_state("post_rst3", 1'b0, 4'd9, 16'h0000, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/line_event_encoder.md
LINE_EVENT_ENCODER -- requirements
Module: line_event_encoder

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of one-hot event lines.
REQ-002 SHALL have parameter DROP_W, default 8, width of the drop counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port line_in  input  16  event strobes; bit i is wired to the 4-to-16 decoder output poi.
REQ-006 SHALL have port idx_out  output  4  index of the granted event line.
REQ-007 SHALL have port idx_valid  output  1  idx_out holds a valid event.
REQ-008 SHALL have port idx_ready  input  1  consumer accepts idx_out this cycle.
REQ-009 SHALL have port pending  output  16  sticky per-line event register, for visibility only.
REQ-010 SHALL have port drop_cnt  output  8  saturating count of cycles with at least one dropped event.

Function
REQ-011 SHALL OR line_in into pending on every rising edge: pending_next = (pending & ~grant_mask) | line_in.
REQ-012 SHALL treat line_in as level-sampled per cycle; a bit held high for k cycles is k events on that line.
REQ-013 SHALL have an output register that is "free" when idx_valid=0 or (idx_valid=1 and idx_ready=1).
REQ-014 SHALL, when the output register is free and pending!=0, pick one pending bit round-robin, starting at (last_idx+1) mod 16 and searching upward with wrap.
REQ-015 SHALL, on a pick, load idx_out with the picked index, set idx_valid=1, set last_idx to the picked index, and clear that bit via grant_mask, all on the same edge.
REQ-016 SHALL, when the output register is free and pending==0, clear idx_valid to 0 and leave idx_out unchanged.
REQ-017 SHALL hold idx_out and idx_valid stable while idx_valid=1 and idx_ready=0.
REQ-018 SHALL pick only from registered pending, never from line_in directly.
REQ-019 SHALL have a latency of 2 edges: line_in sampled at edge E sets pending at E; with the output free and no competing bits, idx_valid=1 and idx_out=i after edge E+1.
REQ-020 SHALL sustain a throughput of one index per cycle while idx_ready=1 and pending!=0.
REQ-021 SHALL, when line_in[i]=1 on the same edge that bit i is granted, leave pending[i]=1 as a new event and not count a drop.
REQ-022 SHALL count a drop when line_in[i]=1, pending[i]=1 and bit i is not granted on that edge.
REQ-023 SHALL increment drop_cnt by exactly 1 per cycle with any drop, regardless of how many bits dropped, saturating at 255 with no wrap.
REQ-024 SHALL accept multiple simultaneous line_in bits, even though the decoder guarantees at most one; all of them set pending.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force pending=0, idx_valid=0, idx_out=0, drop_cnt=0 and last_idx=15, so the first search starts at 0.
REQ-026 SHALL lose any event present on line_in during a cycle in which rst_n=0.
REQ-027 SHALL, on reset mid-transfer, discard the held index without any handshake with the consumer.
REQ-028 SHALL use the first rising edge after rst_n deasserts as a normal sampling edge.

Structure
REQ-029 SHALL define NUM_LINES=16, IDX_W=4 and DROP_W=8 in a shared package, line_event_pkg, which is also used by the decoder-side testbench.
REQ-030 SHALL place the combinational round-robin search in one sub-module, rr_pick16, with inputs req[15:0] and start[3:0] and outputs found and idx[3:0].
REQ-031 SHALL keep all registers in line_event_encoder, with no other sub-modules.

Verification
REQ-032 SHALL cover: reset, then line_in=0x0001 for 1 cycle with idx_ready=1 -> idx_valid=1 and idx_out=0 two edges later, pending=0 afterwards, drop_cnt=0.
REQ-033 SHALL cover: line_in=0x8101 in one cycle with idx_ready=1 -> idx_out sequence 0, 8, 15 on consecutive cycles, then idx_valid=0.
REQ-034 SHALL cover: idx_ready=0 with a single pulse on line 5 -> idx_out=5 held stable for 10 cycles; a second pulse on line 5 meanwhile is absorbed by pending with drop_cnt=0; on ready, 5 is issued twice.
REQ-035 SHALL cover: idx_ready=0 with line 3 pulsed in 3 separate cycles -> first pulse goes to the output register, second sets pending[3], third gives drop_cnt=1.
REQ-036 SHALL cover: line_in[7] held high across the edge at which bit 7 is granted -> pending[7] stays 1, drop_cnt unchanged; also drop_cnt forced past 255 -> stays 255.
REQ-037 SHALL cover: rst_n pulsed low while idx_valid=1 and pending=0x00F0 -> all outputs 0 immediately, with no edge needed; after release, line 2 is issued first despite any earlier last_idx.
